// File: rtl/bnn_pkg.sv
// Shared state encoding and elaboration-time helpers for the BNN neuron scheduler.
package bnn_pkg;

    typedef enum logic [2:0] {
        LOAD = 3'd0,
        CLR  = 3'd1,
        RUN  = 3'd2,
        PUT  = 3'd3,
        CAPT = 3'd4,
        DONE = 3'd5
    } state_t;

    // Ceiling log2, never below 1 so a single-entry counter still gets a bit.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r = r + 1;
        return (r == 0) ? 32'd1 : r;
    endfunction

    // M signed terms of B bits fit in B+N bits only while M <= 2^(N-1).
    function automatic bit headroom_ok(input int unsigned m, input int unsigned n);
        return (n >= 1) && (m <= (32'd1 << (n - 1)));
    endfunction

endpackage

// File: rtl/bnn_neuron_sched_if.sv
// Feature stream, activation stream and accumulator control bundle for bnn_neuron_sched.
interface bnn_neuron_sched_if #(
    parameter int unsigned M = 8,
    parameter int unsigned K = 4,
    parameter int unsigned B = 8
);
    logic           in_valid;
    logic           in_ready;
    logic [B-1:0]   in_data;
    logic [K*M-1:0] weights;
    logic           out_valid;
    logic           out_ready;
    logic [K-1:0]   out_bits;
    logic           acc_rst;
    logic           acc_put;
    logic           acc_add_sub;
    logic [B-1:0]   acc_data;
    logic           acc_out;

    // Scheduler side
    modport slave (
        input  in_valid, in_data, weights, out_ready, acc_out,
        output in_ready, out_valid, out_bits, acc_rst, acc_put, acc_add_sub, acc_data
    );

    // Producer / consumer / accumulator side
    modport master (
        output in_valid, in_data, weights, out_ready, acc_out,
        input  in_ready, out_valid, out_bits, acc_rst, acc_put, acc_add_sub, acc_data
    );
endinterface

// File: rtl/accum.sv
// Binarized-neuron sign accumulator: signed add/subtract of an unsigned operand, sign latched on put.
module accum #(
    parameter int unsigned N = 4,
    parameter int unsigned B = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         put,
    input  logic         add_sub,
    input  logic [B-1:0] data,
    output logic         sign
);
    localparam int unsigned W = B + N;

    logic signed [W-1:0] sum;
    logic signed [W-1:0] operand;

    assign operand = W'(data);

    always_ff @(posedge clk) begin
        if (clr)          sum <= '0;
        else if (add_sub) sum <= sum + operand;
        else              sum <= sum - operand;
        // Result is 1 for sum >= 0, so a zero sum reports 1.
        if (put) sign <= ~sum[W-1];
    end
endmodule

// File: rtl/bnn_feat_buf.sv
// M x B feature register file: one synchronous write port, one asynchronous read port.
module bnn_feat_buf
    import bnn_pkg::*;
#(
    parameter int unsigned M = 8,
    parameter int unsigned B = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [clog2(M)-1:0]   waddr,
    input  logic [B-1:0]          wdata,
    input  logic [clog2(M)-1:0]   raddr,
    output logic [B-1:0]          rdata
);
    logic [B-1:0] mem [M];

    // Contents need no reset: every entry is written before it is read.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/bnn_neuron_sched.sv
// Time-shares one sign accumulator across K binarized neurons over a buffered M-feature vector.
module bnn_neuron_sched
    import bnn_pkg::*;
#(
    parameter int unsigned M = 8,
    parameter int unsigned K = 4,
    parameter int unsigned B = 8,
    parameter int unsigned N = 4
) (
    input  logic               clk,
    input  logic               rst,
    bnn_neuron_sched_if.slave  bus
);
    localparam int unsigned IW = clog2(M);
    localparam int unsigned NW = clog2(K);
    localparam logic [IW-1:0] IDX_LAST = IW'(M - 1);
    localparam logic [NW-1:0] NRN_LAST = NW'(K - 1);

    if (!headroom_ok(M, N)) begin : g_headroom_fail
        $error("bnn_neuron_sched: M exceeds 2^(N-1), accumulator would overflow");
    end

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   idx_nxt;
    logic [NW-1:0]   nrn;
    logic [NW-1:0]   nrn_nxt;
    logic            buf_we;
    logic            capt;
    logic [B-1:0]    rdata;
    logic [M-1:0]    nrn_w;
    logic [K-1:0]    out_bits_q;

    bnn_feat_buf #(.M(M), .B(B)) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (idx),
        .wdata (bus.in_data),
        .raddr (idx),
        .rdata (rdata)
    );

    // Weight row of the neuron currently being evaluated.
    always_comb begin
        nrn_w = '0;
        for (int k = 0; k < K; k++) begin
            if (nrn == NW'(k)) nrn_w = bus.weights[k*M +: M];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= LOAD;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        idx_nxt         = idx;
        nrn_nxt         = nrn;
        buf_we          = 1'b0;
        capt            = 1'b0;
        bus.in_ready    = 1'b0;
        bus.out_valid   = 1'b0;
        bus.acc_rst     = ~rst;
        bus.acc_put     = 1'b0;
        bus.acc_add_sub = 1'b1;
        bus.acc_data    = '0;

        case (state)
            LOAD: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    buf_we = 1'b1;
                    if (idx == IDX_LAST) begin
                        idx_nxt   = '0;
                        nrn_nxt   = '0;
                        state_nxt = CLR;
                    end else begin
                        idx_nxt = idx + IW'(1);
                    end
                end
            end
            CLR: begin
                bus.acc_rst = 1'b1;
                state_nxt   = RUN;
            end
            RUN: begin
                bus.acc_data    = rdata;
                bus.acc_add_sub = nrn_w[idx];
                if (idx == IDX_LAST) begin
                    idx_nxt   = '0;
                    state_nxt = PUT;
                end else begin
                    idx_nxt = idx + IW'(1);
                end
            end
            PUT: begin
                // Zero operand with add keeps the put cycle from contributing a term.
                bus.acc_put = 1'b1;
                state_nxt   = CAPT;
            end
            CAPT: begin
                capt = 1'b1;
                if (nrn == NRN_LAST) begin
                    state_nxt = DONE;
                end else begin
                    nrn_nxt   = nrn + NW'(1);
                    state_nxt = CLR;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end

    // Counters and the activation register; activations hold until overwritten.
    always_ff @(posedge clk) begin
        if (!rst) begin
            idx        <= '0;
            nrn        <= '0;
            out_bits_q <= '0;
        end else begin
            idx <= idx_nxt;
            nrn <= nrn_nxt;
            for (int k = 0; k < K; k++) begin
                if (capt && (nrn == NW'(k))) out_bits_q[k] <= bus.acc_out;
            end
        end
    end

    assign bus.out_bits = out_bits_q;
endmodule
